// File: rtl/fp_pkg.sv
// Shared constants, FSM states and operand classifiers for the sqrt issue path.
package fp_pkg;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  // True for +0 and -0; the sign bit is ignored.
  function automatic logic is_zero(input logic [31:0] op);
    return (op[30:0] == 31'd0);
  endfunction

  // True for any value with the sign bit set; callers test is_zero first.
  function automatic logic is_neg(input logic [31:0] op);
    return op[31];
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Request FIFO: DEPTH entries of {tag, operand}, head visible without a pop.
module fp_req_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  // Entry storage; contents are only meaningful below count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fsqrt_issue_seq.sv
// Sequencer in front of the iterative sqrt unit: queues requests, resolves
// zero/negative operands locally, issues the rest one at a time and returns
// tagged results through a single valid/ready response slot.
module fsqrt_issue_seq
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_operand,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    sq_valid,
  output logic [31:0]             sq_operand,
  input  logic                    sq_halt,
  input  logic [31:0]             sq_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_result,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_invalid,
  output logic                    rsp_timeout,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = 32 + TAG_W;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [31:0]        op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               sq_valid_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_result_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               rsp_invalid_q;
  logic               rsp_timeout_q;
  logic [WW-1:0]      wdog_q;

  logic [PW-1:0]      fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [31:0]        head_op;
  logic [TAG_W-1:0]   head_tag;
  logic               push_c;
  logic               pop_c;
  logic               slot_free_c;

  assign head_op     = fifo_head[31:0];
  assign head_tag    = fifo_head[PW-1:32];
  assign req_ready   = ~fifo_full;
  assign push_c      = req_valid & req_ready;
  // The slot counts as free when it is empty or being drained this cycle.
  assign slot_free_c = ~rsp_valid_q | rsp_ready;
  assign pop_c       = (state_q == IDLE) & ~fifo_empty & slot_free_c;

  fp_req_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i ({req_tag, req_operand}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Issue FSM, operand hold register, watchdog and response slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      tag_q         <= '0;
      sq_valid_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_invalid_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      sq_valid_q <= 1'b0;
      if (rsp_ready) rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop_c) begin
            if (is_zero(head_op)) begin
              rsp_valid_q   <= 1'b1;
              rsp_result_q  <= head_op;
              rsp_tag_q     <= head_tag;
              rsp_invalid_q <= 1'b0;
              rsp_timeout_q <= 1'b0;
            end else if (is_neg(head_op)) begin
              rsp_valid_q   <= 1'b1;
              rsp_result_q  <= QNAN;
              rsp_tag_q     <= head_tag;
              rsp_invalid_q <= 1'b1;
              rsp_timeout_q <= 1'b0;
            end else begin
              op_q       <= head_op;
              tag_q      <= head_tag;
              sq_valid_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (state_q == WAIT_DONE && !sq_halt) begin
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= sq_result;
            rsp_tag_q     <= tag_q;
            rsp_invalid_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= QNAN;
            rsp_tag_q     <= tag_q;
            rsp_invalid_q <= 1'b0;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wdog_q <= wdog_q + WW'(1);
            if (sq_halt) state_q <= WAIT_DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sq_valid    = sq_valid_q;
  assign sq_operand  = op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_invalid = rsp_invalid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign occupancy   = fifo_count;

endmodule

// File: doc/fsqrt_issue_seq.md
Name: fsqrt_issue_seq

Overview:
- Request sequencer sitting directly upstream of the iterative square-root unit.
- Buffers sqrt requests (operand + destination tag) from the FP dispatch stage and issues them one at a time using the unit's valid/halt protocol.
- Holds the operand stable for the whole computation and captures the result into a tagged valid/ready response slot for writeback.
- Resolves special operands (±0, negative) locally without occupying the unit.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, ≥2).
- TAG_W, 5, destination tag width.
- TIMEOUT, 15, max cycles spent in WAIT_BUSY + WAIT_DONE before an op is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_operand  in  32  IEEE-754 single operand.
- req_tag  in  TAG_W  destination tag.
- sq_valid  out  1  start pulse to sqrt unit.
- sq_operand  out  32  operand to sqrt unit, held stable.
- sq_halt  in  1  sqrt unit busy.
- sq_result  in  32  sqrt unit result.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  writeback accepts.
- rsp_result  out  32  result.
- rsp_tag  out  TAG_W  tag of result.
- rsp_invalid  out  1  negative non-zero operand.
- rsp_timeout  out  1  op aborted by watchdog.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, sq_valid=0, sq_operand=0, rsp_valid=0, rsp_result=0, rsp_tag=0, both flags 0, occupancy=0.
- The sqrt unit is reset concurrently by the top level.
- Enqueue on req_valid & req_ready. Dequeue only in IDLE.
- Simultaneous push and pop when full is allowed: occupancy is unchanged and req_ready stays 0 that cycle.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Acts only when the FIFO is non-empty and the response slot is free (rsp_valid=0, or rsp_ready=1 this cycle).
  - Head is ±0 (bits[30:0]=0): pop; load the response with result = operand (sign preserved), invalid=0; stay IDLE.
  - Head is negative non-zero: pop; load result 0x7FC00000, invalid=1; stay IDLE.
  - Otherwise: pop into the hold register (operand, tag) and go to ISSUE.
- ISSUE: sq_valid=1 for exactly one cycle; next state WAIT_BUSY.
- WAIT_BUSY: on sq_halt=1, go to WAIT_DONE.
- WAIT_DONE: on sq_halt=0, capture sq_result and the held tag into the response (flags 0); go to IDLE.
- sq_operand is driven from the hold register and must not change from ISSUE until the WAIT_DONE capture. The unit reads it combinationally throughout.
- sq_valid is 0 in all states except ISSUE. A lingering valid would restart the unit.
- Watchdog: a counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY/WAIT_DONE. At TIMEOUT, load result 0x7FC00000 with timeout=1 and go to IDLE.
- Response slot: rsp_valid clears on rsp_ready. The slot can be refilled in the same cycle it is drained.
- Latency, empty FIFO, nominal unit:
  - Normal op: rsp_valid asserts 9 cycles after request acceptance.
  - Special operand: 2 cycles after acceptance.
- Throughput: one normal op per 8 cycles when rsp_ready is held high.
- Reset mid-operation abandons the in-flight op; no response is produced.

Decomposition:
- Package fp_pkg: QNAN=32'h7FC00000, state enum {IDLE,ISSUE,WAIT_BUSY,WAIT_DONE}, is_zero/is_neg helper functions.
- Sub-module fp_req_fifo: synchronous FIFO with DEPTH×(32+TAG_W) storage, full/empty/count outputs, async active-low reset.

Test Plan:
- Push operand 0x40800000 (4.0), tag 3, rsp_ready=1.
  - sq_valid pulses once.
  - sq_operand stays stable until sq_halt falls.
  - rsp_valid at +9 cycles with rsp_result equal to the unit output, tag 3, flags 0.
- Push 0x80000000 then 0xC0000000.
  - Sqrt unit is never issued.
  - Response 1: 0x80000000, invalid=0.
  - Response 2: 0x7FC00000, invalid=1.
- Push 5 ops back-to-back with DEPTH=4 and rsp_ready=0.
  - req_ready drops after 4 entries.
  - Only one op reaches the unit; the rest stay queued.
  - Raising rsp_ready drains all 5 in order with correct tags.
- Model sq_halt stuck at 0 after issue.
  - After TIMEOUT cycles, response is 0x7FC00000 with timeout=1.
  - Next queued op then issues normally.
- Assert rst=0 while in WAIT_DONE.
  - All outputs return to reset values immediately.
  - No response for the in-flight op; occupancy=0.
- Hold rsp_valid=1 with rsp_ready=1 while the next op's sq_halt falls.
  - Old response is drained and the new one loaded in the same cycle; no loss, no duplicate.
